dmem_access_u: RTL
==================

# dmem_access_u

MEM-stage data-memory access unit for the RV32I pipeline. It turns a load or store in MEM into a byte-lane data-memory request and holds that request until the memory acknowledges it. It aligns and extends load data, and supplies the filtered `dmem_ack_n` that the interlock unit consumes. A DONE state keeps a completed access from being re-issued while the pipeline is still frozen by an instruction-memory stall.

## Interface
- No parameters. XLEN is fixed at 32.
- `clk` in 1: pipeline clock.
- `rst_n` in 1: reset, synchronous and active-low. One clock; no other clock domain.
- `stall` in 1: pipeline interlock for this cycle (interlock unit output); 1 = MEM instruction is held.
- `ir_type` in 4: MEM-stage instruction class, encoded as `LOAD_IR`, `STORE_IR`, etc.
- `funct3` in 3: MEM-stage funct3.
- `addr` in 32: effective address from EX/MEM.
- `wdata_in` in 32: store source (rs2).
- `dmem_req` out 1: request valid.
- `dmem_wr` out 1: 1 = write.
- `dmem_addr` out 32: word address, `{addr[31:2],2'b00}`.
- `dmem_be` out 4: byte enables, little-endian.
- `dmem_wdata` out 32: lane-replicated store data.
- `dmem_rdata` in 32: read data; valid when `dmem_ack_n`=0.
- `dmem_ack_n` in 1: 0 = access complete this cycle.
- `ack_n_to_il` out 1: filtered ack to the interlock unit.
- `load_data` out 32: extended load result to WB.
- `misaligned` out 1: 1 = address misaligned for the access size; no access is issued.

## Operation
- An access is pending when `ir_type` is `LOAD_IR` or `STORE_IR` and the address is not misaligned.
- Misalignment rules:
  - halfword (funct3[1:0]=01) with `addr[0]`=1 is misaligned;
  - word (10) with `addr[1:0]`≠00 is misaligned;
  - byte is never misaligned.
- Byte enables:
  - byte: `4'b0001<<addr[1:0]`;
  - half: `4'b0011<<addr[1:0]`;
  - word: `4'b1111`.
- Store data:
  - SB replicates `wdata_in[7:0]` ×4;
  - SH replicates `wdata_in[15:0]` ×2;
  - SW passes `wdata_in` through.
- Load extract: shift `dmem_rdata` right by `8*addr[1:0]`, then extend:
  - LB: sign-extend 8 bits; LBU: zero-extend 8 bits;
  - LH: sign-extend 16 bits; LHU: zero-extend 16 bits;
  - LW: pass through.
  - Any other funct3 returns 0.
- FSM states are IDLE, BUSY and DONE.
- IDLE:
  - With an access pending, assert `dmem_req` combinationally in the same cycle.
  - If `dmem_ack_n`=0 and `stall`=1, go to DONE and capture the extended load.
  - If `dmem_ack_n`=0 and `stall`=0, stay in IDLE.
  - If `dmem_ack_n`=1, go to BUSY.
- BUSY:
  - Hold `dmem_req`, `dmem_wr`, `dmem_addr`, `dmem_be` and `dmem_wdata` stable.
  - On `dmem_ack_n`=0, capture, then go to DONE if `stall`=1, otherwise to IDLE.
- DONE:
  - `dmem_req`=0 and `ack_n_to_il`=0.
  - `load_data` comes from the capture register.
  - Return to IDLE in the first cycle with `stall`=0.
- `ack_n_to_il`:
  - equals `dmem_ack_n` in IDLE and BUSY when an access is pending;
  - is 0 in DONE, when no access is pending, and on misaligned accesses.
- `load_data` is combinational from `dmem_rdata` on the ack cycle; otherwise it comes from the capture register.
- `misaligned` is combinational; trap handling lives downstream.
- `ir_type`/`addr` changing while in BUSY is illegal: the pipeline is stalled. The bench asserts against it.

## Timing
- While `rst_n`=0 at a clock edge:
  - state becomes IDLE and the capture register becomes 0;
  - the cycle after, `dmem_req`, `dmem_wr`, `dmem_be` and `ack_n_to_il` are 0 unless a pending access exists.
- During reset assertion, all request outputs are gated to 0.
- Reset in BUSY abandons the transaction: the memory model must tolerate a dropped request.
- Latency:
  - zero-wait memory: load result valid in the same cycle as the request;
  - N wait cycles: the request is held N+1 cycles, and the result is valid in the ack cycle.
- Exactly one request is issued per MEM instruction. A store is never re-issued while in DONE.
- Ack and imem stall in the same cycle → DONE. Data stays stable until `stall` falls.
- Back-to-back loads in consecutive cycles: the second request is issued in the cycle the FSM is back in IDLE, with no bubble.

## Structure
- `constants/ir_type.v` (existing) supplies `LOAD_IR` and `STORE_IR`.
- New `constants/funct3.v` holds the LB/LH/LW/LBU/LHU/SB/SH/SW codes.
- FSM state encoding stays local to the module.
- One combinational sub-module, `load_align_u` (rdata, addr[1:0], funct3 → load_data), is shared with the capture path.

## Test plan
- SW `addr`=0x104, `wdata_in`=0xDEADBEEF, ack immediate, `stall`=0 → one-cycle `dmem_req`, `dmem_be`=1111, `dmem_wdata`=0xDEADBEEF, FSM stays IDLE.
- LB `addr`=0x203, `dmem_rdata`=0x80112233, ack after 3 wait cycles → `ack_n_to_il`=1 for 3 cycles, request held stable, `load_data`=0xFFFFFF80. With LBU instead: 0x00000080.
- SH `addr`=0x302, `wdata_in`=0x0000ABCD, ack with `stall`=1 (imem) for 4 more cycles → exactly one write beat with `dmem_be`=1100, `dmem_wdata`=0xABCDABCD; DONE until `stall`=0, with `dmem_req`=0 throughout.
- LW `addr`=0x401 → `misaligned`=1, `dmem_req`=0, `ack_n_to_il`=0. LH `addr`=0x403 → same.
- `rst_n`=0 for one edge mid-BUSY → next cycle IDLE, capture register 0. Then LHU `addr`=0x2, `dmem_rdata`=0xF00D1234 → `load_data`=0x0000F00D.

Source files
------------

// File: rtl/dmem_access_u_pkg.sv
// Shared constants and helpers for the MEM-stage data-memory access unit:
// instruction classes, funct3 codes and the size/lane arithmetic that both
// the request path and the load-alignment path depend on.
package dmem_access_u_pkg;

  // MEM-stage instruction class.
  typedef enum logic [3:0] {
    ALU_IR    = 4'h0,
    IMM_IR    = 4'h1,
    LUI_IR    = 4'h2,
    AUIPC_IR  = 4'h3,
    JAL_IR    = 4'h4,
    JALR_IR   = 4'h5,
    BRANCH_IR = 4'h6,
    LOAD_IR   = 4'h7,
    STORE_IR  = 4'h8,
    SYS_IR    = 4'h9
  } ir_type_e;

  // Load funct3 codes.
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Store funct3 codes.
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Access size, taken directly from funct3[1:0]. The reserved code is
  // handled like a word so it never produces a partial lane pattern.
  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } mem_size_e;

  function automatic mem_size_e size_of(input logic [2:0] funct3);
    return mem_size_e'(funct3[1:0]);
  endfunction

  // Halfwords need an even address, words a 4-byte aligned one.
  function automatic logic is_misaligned(input mem_size_e  size,
                                         input logic [1:0] byte_off);
    logic mis;
    case (size)
      SZ_BYTE: mis = 1'b0;
      SZ_HALF: mis = byte_off[0];
      default: mis = (byte_off != 2'b00);
    endcase
    return mis;
  endfunction

  // Little-endian byte enables for an aligned access.
  function automatic logic [3:0] byte_enables(input mem_size_e  size,
                                              input logic [1:0] byte_off);
    logic [3:0] be;
    case (size)
      SZ_BYTE: be = 4'b0001 << byte_off;
      SZ_HALF: be = 4'b0011 << byte_off;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Store data is replicated across lanes so the memory only has to honour
  // the byte enables; no shifter is needed on the write side.
  function automatic logic [31:0] store_lanes(input mem_size_e   size,
                                              input logic [31:0] wdata);
    logic [31:0] lanes;
    case (size)
      SZ_BYTE: lanes = {4{wdata[7:0]}};
      SZ_HALF: lanes = {2{wdata[15:0]}};
      default: lanes = wdata;
    endcase
    return lanes;
  endfunction

endpackage : dmem_access_u_pkg

// File: rtl/dmem_access_u_if.sv
// Pipeline-side and memory-side signals of the data-memory access unit.
// The access unit uses the master modport; a memory model or the pipeline
// environment uses the slave modport.
interface dmem_access_u_if;

  // Pipeline / MEM stage.
  logic        stall;
  logic [3:0]  ir_type;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata_in;

  // Data-memory request.
  logic        dmem_req;
  logic        dmem_wr;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;

  // Data-memory response.
  logic [31:0] dmem_rdata;
  logic        dmem_ack_n;

  // Results towards the interlock unit and write-back.
  logic        ack_n_to_il;
  logic [31:0] load_data;
  logic        misaligned;

  modport master (
    input  stall,
    input  ir_type,
    input  funct3,
    input  addr,
    input  wdata_in,
    input  dmem_rdata,
    input  dmem_ack_n,
    output dmem_req,
    output dmem_wr,
    output dmem_addr,
    output dmem_be,
    output dmem_wdata,
    output ack_n_to_il,
    output load_data,
    output misaligned
  );

  modport slave (
    output stall,
    output ir_type,
    output funct3,
    output addr,
    output wdata_in,
    output dmem_rdata,
    output dmem_ack_n,
    input  dmem_req,
    input  dmem_wr,
    input  dmem_addr,
    input  dmem_be,
    input  dmem_wdata,
    input  ack_n_to_il,
    input  load_data,
    input  misaligned
  );

endinterface : dmem_access_u_if

// File: rtl/dmem_access_u_load_align.sv
// Load alignment: shifts the addressed byte/halfword down to bit 0 and
// extends it according to funct3. Purely combinational; the same result
// feeds both the live load_data path and the capture register.
module load_align_u
  import dmem_access_u_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  byte_off_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] load_data_o
);

  logic [31:0] shifted;

  // Right-justify the addressed lane, then extend by load type.
  always_comb begin
    shifted     = rdata_i >> {byte_off_i, 3'b000};
    load_data_o = '0;
    case (funct3_i)
      F3_LB:   load_data_o = {{24{shifted[7]}}, shifted[7:0]};
      F3_LBU:  load_data_o = {24'h0, shifted[7:0]};
      F3_LH:   load_data_o = {{16{shifted[15]}}, shifted[15:0]};
      F3_LHU:  load_data_o = {16'h0, shifted[15:0]};
      F3_LW:   load_data_o = shifted;
      default: load_data_o = '0;
    endcase
  end

endmodule : load_align_u

// File: rtl/dmem_access_u.sv
// MEM-stage data-memory access unit. Issues one byte-lane request per
// load/store, holds it until the memory acks, aligns/extends load data,
// and filters the ack seen by the interlock unit. DONE parks a completed
// access while an instruction-memory stall keeps the pipeline frozen, so
// the same instruction is never issued twice.
module dmem_access_u
  import dmem_access_u_pkg::*;
(
  input logic            clk,
  input logic            rst_n,
  dmem_access_u_if.master mem_if
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] capture_q, capture_d;

  mem_size_e   access_size;
  logic        is_mem;
  logic        is_store;
  logic        misaligned_c;
  logic        pending;
  logic        ack;
  logic        issue;
  logic        issue_g;
  logic        ack_cycle;
  logic [31:0] aligned_data;

  assign ack = ~mem_if.dmem_ack_n;

  // Decode the MEM-stage instruction into size, alignment and pending.
  always_comb begin
    access_size  = size_of(mem_if.funct3);
    is_store     = (mem_if.ir_type == STORE_IR);
    is_mem       = (mem_if.ir_type == LOAD_IR) || is_store;
    misaligned_c = is_mem && is_misaligned(access_size, mem_if.addr[1:0]);
    pending      = is_mem && !misaligned_c;
  end

  load_align_u u_load_align (
    .rdata_i     (mem_if.dmem_rdata),
    .byte_off_i  (mem_if.addr[1:0]),
    .funct3_i    (mem_if.funct3),
    .load_data_o (aligned_data)
  );

  // Next state, request issue and capture decisions.
  // NOTE: every variable gets a default before the case so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    capture_d = capture_q;
    issue     = 1'b0;
    ack_cycle = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pending) begin
          issue = 1'b1;
          if (ack) begin
            ack_cycle = 1'b1;
            // Only a frozen pipeline needs the result parked; otherwise
            // WB takes it straight from the live path this cycle.
            if (mem_if.stall) begin
              state_d   = ST_DONE;
              capture_d = aligned_data;
            end
          end else begin
            state_d = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        if (!pending) begin
          // Instruction vanished under a held request: drop it.
          state_d = ST_IDLE;
        end else begin
          issue = 1'b1;
          if (ack) begin
            ack_cycle = 1'b1;
            capture_d = aligned_data;
            state_d   = mem_if.stall ? ST_DONE : ST_IDLE;
          end
        end
      end
      ST_DONE: begin
        if (!mem_if.stall) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and capture registers with synchronous active-low reset.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  // NOTE: the capture register is reset too, because load_data reads it
  // directly whenever no ack is in progress.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      capture_q <= '0;
    end else begin
      state_q   <= state_d;
      capture_q <= capture_d;
    end
  end

  // Request outputs are gated while reset is asserted. Inputs are held
  // stable by the stalled pipeline in BUSY, so the decoded request fields
  // stay stable without extra registers.
  assign issue_g            = issue & rst_n;
  assign mem_if.dmem_req    = issue_g;
  assign mem_if.dmem_wr     = issue_g & is_store;
  assign mem_if.dmem_be     = issue_g ? byte_enables(access_size, mem_if.addr[1:0]) : 4'b0000;
  assign mem_if.dmem_addr   = {mem_if.addr[31:2], 2'b00};
  assign mem_if.dmem_wdata  = store_lanes(access_size, mem_if.wdata_in);

  // The interlock sees the raw ack only while a request is on the bus.
  assign mem_if.ack_n_to_il = issue_g & mem_if.dmem_ack_n;

  assign mem_if.load_data   = ack_cycle ? aligned_data : capture_q;
  assign mem_if.misaligned  = misaligned_c;

endmodule : dmem_access_u
